aesl_deadlock_report_ctrl: RTL and testbench
============================================

Name: aesl_deadlock_report_ctrl

Overview:
Central collector on the consuming end of the per-process deadlock detect units in the co-simulation dataflow harness. It gathers every unit's dl_detect_out, debounces it, and picks one origin process. It then drives origin, dl_detect_in and token_clear back to the units, traces the token around the dependency cycle, and emits a single report record (origin, path, status, timestamp) over a valid/ready handshake.

Parameters:
PROC_NUM, 4, number of dataflow processes / detect units
MAX_PATH, 8, maximum process IDs recorded in the cycle path
DEBOUNCE, 4, consecutive cycles dl_detect must persist before confirmation
TRACE_TIMEOUT, 64, cycles with no token seen before the trace is aborted
IDW, $clog2(PROC_NUM) (min 1), process-ID width (derived)
LENW, $clog2(MAX_PATH+1), path-length width (derived)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
dl_detect_vec  in  PROC_NUM  dl_detect_out of each detect unit, bit i = process i
proc_token_vec  in  PROC_NUM  bit i = OR of process i's token_in_vec (token currently held)
origin_vec  out  PROC_NUM  one-hot origin select, one-cycle pulse
dl_detect_in  out  1  global "deadlock under trace" broadcast to all units
token_clear  out  1  one-cycle pulse ending token circulation
report_valid  out  1  report record valid
report_ready  in  1  consumer accepts record
report_origin  out  IDW  origin process ID
report_len  out  LENW  number of valid path entries
report_path  out  MAX_PATH*IDW  path entries, entry k at [k*IDW +: IDW], entry 0 = first hop
report_status  out  2  OK / TIMEOUT / MULTI / OVERFLOW
report_cycle  out  32  free-running cycle count latched at confirmation
deadlock_halted  out  1  sticky: report delivered, block halted

Behaviour:
- Reset (sync, high): state IDLE. All outputs 0, path buffer cleared, cycle counter 0. Reset in any state aborts the operation within one cycle. Any in-flight report is dropped.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps to 0.
- IDLE: deb_cnt counts while |dl_detect_vec and clears to 0 when none is asserted. On deb_cnt reaching DEBOUNCE-1 with any bit still set: latch sel = lowest-index set bit, latch report_cycle, go ORIGIN. DEBOUNCE=1 confirms on the first asserted cycle.
- ORIGIN (1 cycle): origin_vec = 1<<sel, dl_detect_in=1. Go TRACE with len=0 and idle_cnt=0.
- TRACE: dl_detect_in=1.
  - popcount(proc_token_vec)==0: idle_cnt++. On reaching TRACE_TIMEOUT, status=TIMEOUT and go CLEAR.
  - popcount>=2: status=MULTI, go CLEAR.
  - Exactly one bit p: idle_cnt=0.
    - If p==sel and len>0: status=OK, go CLEAR. The origin is not appended.
    - Else if len==MAX_PATH: status=OVERFLOW, go CLEAR.
    - Else path[len]=p, len++.
  - The same p on consecutive cycles is appended only once; consecutive duplicates are ignored.
- CLEAR (1 cycle): token_clear=1, dl_detect_in=1. Go REPORT.
- REPORT: report_valid=1. All report_* fields stay stable until report_ready is sampled high. On that cycle go HALT. dl_detect_in stays 1.
- HALT: deadlock_halted=1, dl_detect_in=1, all other pulses 0. Exit only by reset. dl_detect_vec is ignored.
- origin_vec and token_clear are never asserted in the same cycle. Each asserts exactly once per detection.
- Status priority within one TRACE cycle: MULTI > OK > OVERFLOW > append.

Decomposition:
- Package aesl_dl_pkg:
  - state enum (IDLE, ORIGIN, TRACE, CLEAR, REPORT, HALT)
  - status codes: OK=0, TIMEOUT=1, MULTI=2, OVERFLOW=3
  - functions clog2_min1 and lowest_set_index
- One sub-module, aesl_dl_path_buf: MAX_PATH x IDW register array with append, clear and a len counter. The FSM, counters and handshake stay in the top module.

Test Plan:
- PROC_NUM=4, DEBOUNCE=4: dl_detect_vec=0b0100 for 3 cycles, then 0 -> no origin pulse, state stays IDLE. Then held for 4 cycles -> origin_vec=0b0100 exactly one cycle later.
- Origin 2, proc_token_vec sequence 0001,0001,1000,0100 -> token_clear pulse, then report_valid with origin=2, len=2, path={0,3}, status=OK.
- Report held with report_ready=0 for 10 cycles -> all report fields stable. Raise ready -> deadlock_halted=1 next cycle, report_valid=0.
- dl_detect_vec=0b1010 -> sel=1. proc_token_vec=0b0110 in TRACE -> status=MULTI, len=0.
- TRACE_TIMEOUT=64, proc_token_vec=0 after origin -> token_clear on the cycle after the 64th idle cycle, status=TIMEOUT.
- MAX_PATH=2, tokens 0,3,1 with origin 2 -> status=OVERFLOW, len=2. Assert reset during REPORT -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/aesl_dl_pkg.sv
// Shared types and helpers for the deadlock report controller.
// Status codes travel in the report record, so their encodings are fixed.
package aesl_dl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ORIGIN,
        S_TRACE,
        S_CLEAR,
        S_REPORT,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_TIMEOUT  = 2'd1,
        ST_MULTI    = 2'd2,
        ST_OVERFLOW = 2'd3
    } status_t;

    localparam int unsigned CYCW = 32;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Index of the lowest set bit, 0 when nothing is set.
    function automatic int lowest_set_index(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/aesl_deadlock_report_ctrl_if.sv
// Report record handshake from the deadlock controller to its consumer.
interface aesl_deadlock_report_ctrl_if #(
    parameter int MAX_PATH = 8,
    parameter int IDW      = 2,
    parameter int LENW     = 4
) ();
    logic                     report_valid;
    logic                     report_ready;
    logic [IDW-1:0]           report_origin;
    logic [LENW-1:0]          report_len;
    logic [MAX_PATH*IDW-1:0]  report_path;
    logic [1:0]               report_status;
    logic [31:0]              report_cycle;

    modport master (
        output report_valid, report_origin, report_len, report_path,
               report_status, report_cycle,
        input  report_ready
    );

    modport slave (
        input  report_valid, report_origin, report_len, report_path,
               report_status, report_cycle,
        output report_ready
    );
endinterface

// File: rtl/aesl_dl_path_buf.sv
// Ordered record of process IDs visited by the token during a trace.
// Appends past MAX_PATH entries are dropped; the controller flags overflow first.
module aesl_dl_path_buf #(
    parameter int MAX_PATH = 8,
    parameter int IDW      = 2,
    parameter int LENW     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    append,
    input  logic [IDW-1:0]          entry,
    output logic [LENW-1:0]         len,
    output logic [MAX_PATH*IDW-1:0] path
);

    logic [IDW-1:0]  mem [MAX_PATH];
    logic [LENW-1:0] len_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int k = 0; k < MAX_PATH; k++) mem[k] <= '0;
            len_q <= '0;
        end else if (append && (len_q < LENW'(MAX_PATH))) begin
            for (int k = 0; k < MAX_PATH; k++) begin
                if (len_q == LENW'(k)) mem[k] <= entry;
            end
            len_q <= len_q + 1'b1;
        end
    end

    always_comb begin
        path = '0;
        for (int k = 0; k < MAX_PATH; k++) path[k*IDW +: IDW] = mem[k];
    end

    assign len = len_q;

endmodule

// File: rtl/aesl_deadlock_report_ctrl.sv
// Collects detect-unit flags, selects an origin, traces the token around the
// dependency cycle and delivers one report record before halting.
module aesl_deadlock_report_ctrl
    import aesl_dl_pkg::*;
#(
    parameter int PROC_NUM      = 4,
    parameter int MAX_PATH      = 8,
    parameter int DEBOUNCE      = 4,
    parameter int TRACE_TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] proc_token_vec,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                dl_detect_in,
    output logic                token_clear,
    output logic                deadlock_halted,
    aesl_deadlock_report_ctrl_if.master rpt
);

    localparam int IDW  = clog2_min1(PROC_NUM);
    localparam int LENW = $clog2(MAX_PATH + 1);
    localparam int DBW  = clog2_min1(DEBOUNCE);
    localparam int TOW  = clog2_min1(TRACE_TIMEOUT + 1);

    state_t            state, state_n;
    status_t           status_q, trace_status;
    logic [CYCW-1:0]   cyc_cnt, cycle_q;
    logic [DBW-1:0]    deb_cnt;
    logic [TOW-1:0]    idle_cnt, idle_next;
    logic [IDW-1:0]    sel, tok_p, det_p, last_p;
    logic              last_vld;
    logic              confirm, timeout, dup, do_append;
    int                tok_cnt;
    logic [LENW-1:0]   path_len;
    logic [MAX_PATH*IDW-1:0] path_bits;

    assign tok_cnt   = $countones(proc_token_vec);
    assign tok_p     = IDW'(lowest_set_index(32'(proc_token_vec)));
    assign det_p     = IDW'(lowest_set_index(32'(dl_detect_vec)));
    assign confirm   = (|dl_detect_vec) && (deb_cnt == DBW'(DEBOUNCE - 1));
    assign idle_next = idle_cnt + 1'b1;
    assign timeout   = (idle_next == TOW'(TRACE_TIMEOUT));
    // A token that sits on the same process for several cycles is one hop.
    assign dup       = last_vld && (tok_p == last_p);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        trace_status = ST_OK;
        do_append    = 1'b0;
        case (state)
            S_IDLE:   if (confirm) state_n = S_ORIGIN;
            S_ORIGIN: state_n = S_TRACE;
            S_TRACE: begin
                if (tok_cnt == 0) begin
                    if (timeout) begin
                        state_n      = S_CLEAR;
                        trace_status = ST_TIMEOUT;
                    end
                end else if (tok_cnt >= 2) begin
                    state_n      = S_CLEAR;
                    trace_status = ST_MULTI;
                end else if (!dup) begin
                    if ((tok_p == sel) && (path_len != '0)) begin
                        state_n      = S_CLEAR;
                        trace_status = ST_OK;
                    end else if (path_len == LENW'(MAX_PATH)) begin
                        state_n      = S_CLEAR;
                        trace_status = ST_OVERFLOW;
                    end else begin
                        do_append = 1'b1;
                    end
                end
            end
            S_CLEAR:  state_n = S_REPORT;
            S_REPORT: if (rpt.report_ready) state_n = S_HALT;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        origin_vec        = '0;
        dl_detect_in      = (state != S_IDLE);
        token_clear       = (state == S_CLEAR);
        deadlock_halted   = (state == S_HALT);
        rpt.report_valid  = (state == S_REPORT);
        rpt.report_origin = sel;
        rpt.report_len    = path_len;
        rpt.report_path   = path_bits;
        rpt.report_status = status_q;
        rpt.report_cycle  = cycle_q;
        if (state == S_ORIGIN) origin_vec = PROC_NUM'(1) << sel;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt  <= '0;
            cycle_q  <= '0;
            deb_cnt  <= '0;
            idle_cnt <= '0;
            sel      <= '0;
            status_q <= ST_OK;
            last_vld <= 1'b0;
            last_p   <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;

            if ((state == S_IDLE) && (|dl_detect_vec) && !confirm) deb_cnt <= deb_cnt + 1'b1;
            else                                                     deb_cnt <= '0;

            if ((state == S_IDLE) && confirm) begin
                sel      <= det_p;
                cycle_q  <= cyc_cnt;
                status_q <= ST_OK;
            end

            if ((state == S_TRACE) && (tok_cnt == 0)) idle_cnt <= idle_next;
            else                                      idle_cnt <= '0;

            if ((state == S_TRACE) && (tok_cnt == 1)) begin
                last_vld <= 1'b1;
                last_p   <= tok_p;
            end else begin
                last_vld <= 1'b0;
            end

            if ((state == S_TRACE) && (state_n == S_CLEAR)) status_q <= trace_status;
        end
    end

    aesl_dl_path_buf #(
        .MAX_PATH (MAX_PATH),
        .IDW      (IDW),
        .LENW     (LENW)
    ) u_path_buf (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == S_ORIGIN),
        .append (do_append),
        .entry  (tok_p),
        .len    (path_len),
        .path   (path_bits)
    );

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Directed bench: the driver queues expected report records, a monitor checks them.
module tb_aesl_deadlock_report_ctrl;
    import aesl_dl_pkg::*;

    localparam int PROC_NUM = 4;
    localparam int MAX_PATH = 2;
    localparam int IDW      = 2;
    localparam int LENW     = 2;

    typedef struct {
        logic [IDW-1:0]          origin;
        logic [LENW-1:0]         len;
        logic [MAX_PATH*IDW-1:0] path;
        logic [1:0]              status;
        logic [31:0]             cycle;
    } exp_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [PROC_NUM-1:0] dl_detect_vec  = '0;
    logic [PROC_NUM-1:0] proc_token_vec = '0;
    logic [PROC_NUM-1:0] origin_vec;
    logic                dl_detect_in, token_clear, deadlock_halted;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    exp_t        cur;
    logic        have_cur = 1'b0;
    logic [31:0] tb_cyc;

    aesl_deadlock_report_ctrl_if #(.MAX_PATH(MAX_PATH), .IDW(IDW), .LENW(LENW)) rif ();

    aesl_deadlock_report_ctrl #(
        .PROC_NUM(PROC_NUM), .MAX_PATH(MAX_PATH), .DEBOUNCE(4), .TRACE_TIMEOUT(64)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .dl_detect_vec   (dl_detect_vec),
        .proc_token_vec  (proc_token_vec),
        .origin_vec      (origin_vec),
        .dl_detect_in    (dl_detect_in),
        .token_clear     (token_clear),
        .deadlock_halted (deadlock_halted),
        .rpt             (rif)
    );

    always #5 clock = ~clock;

    // Reference free-running cycle counter.
    always @(posedge clock) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_origin_vec"}, 64'(origin_vec), 0);
        chk({tag, "_dl_detect_in"}, 64'(dl_detect_in), 0);
        chk({tag, "_token_clear"}, 64'(token_clear), 0);
        chk({tag, "_halted"}, 64'(deadlock_halted), 0);
        chk({tag, "_valid"}, 64'(rif.report_valid), 0);
        chk({tag, "_fields"}, {rif.report_cycle, 8'(rif.report_path), 6'(rif.report_origin),
                               6'(rif.report_len), 6'(rif.report_status)}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Holds a detect pattern for exactly the debounce window; returns the
    // counter value the controller should latch on the confirming edge.
    task automatic detect(input logic [PROC_NUM-1:0] vec, input logic [PROC_NUM-1:0] exp_origin,
                          output logic [31:0] c);
        dl_detect_vec = vec;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) c = tb_cyc;
            tick();
            if (i < 3) chk("debounce_hold", 64'(origin_vec), 0);
        end
        dl_detect_vec = '0;
        chk("origin_pulse", 64'(origin_vec), 64'(exp_origin));
        chk("origin_dl_in", 64'(dl_detect_in), 1);
        tick();
        chk("origin_one_cycle", 64'(origin_vec), 0);
    endtask

    task automatic tok(input logic [PROC_NUM-1:0] v);
        proc_token_vec = v;
        tick();
    endtask

    // Scoreboard monitor: pops an expectation on each new report and checks
    // every valid cycle until the handshake.
    always @(negedge clock) begin
        if (reset) begin
            have_cur = 1'b0;
        end else begin
            if (rif.report_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_report: origin %0d status %0d", rif.report_origin, rif.report_status);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    total++;
                    if (rif.report_origin !== cur.origin || rif.report_len !== cur.len ||
                        rif.report_path !== cur.path || rif.report_status !== cur.status ||
                        rif.report_cycle !== cur.cycle) begin
                        bad++;
                        $display("FAIL report: got o=%0d l=%0d p=%0h s=%0d c=%0d want o=%0d l=%0d p=%0h s=%0d c=%0d",
                                 rif.report_origin, rif.report_len, rif.report_path, rif.report_status,
                                 rif.report_cycle, cur.origin, cur.len, cur.path, cur.status, cur.cycle);
                    end
                    if (rif.report_ready) have_cur = 1'b0;
                end
            end
            total++;
            if ((origin_vec != '0) && token_clear) begin
                bad++;
                $display("FAIL pulse_overlap: origin_vec %0h token_clear %0d", origin_vec, token_clear);
            end
        end
    end

    initial begin
        logic [31:0] c;
        rif.report_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_all_zero("reset");

        // Short glitch must not confirm.
        dl_detect_vec = 4'b0100;
        for (int i = 0; i < 3; i++) tick();
        dl_detect_vec = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch_no_origin", {60'(origin_vec), 4'(dl_detect_in)}, 0);
        end

        // Origin 2, path 0 -> 3 -> back to 2.
        detect(4'b0100, 4'b0100, c);
        exp_q.push_back('{origin: 2'd2, len: 2'd2, path: 4'b1100, status: 2'(ST_OK), cycle: c});
        tok(4'b0001);
        tok(4'b0001);
        tok(4'b1000);
        tok(4'b0100);
        proc_token_vec = '0;
        chk("ok_token_clear", 64'(token_clear), 1);
        tick();
        chk("ok_clear_one_cycle", 64'(token_clear), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_valid", 64'(rif.report_valid), 1);
        rif.report_ready = 1'b1;
        tick();
        rif.report_ready = 1'b0;
        chk("halt_flag", 64'(deadlock_halted), 1);
        chk("halt_valid", 64'(rif.report_valid), 0);
        chk("halt_dl_in", 64'(dl_detect_in), 1);
        dl_detect_vec = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("halt_ignores_detect", {60'(origin_vec), 2'(token_clear), 2'(deadlock_halted)}, 1);
        end
        dl_detect_vec = '0;

        // Two detectors, lowest wins; two tokens at once aborts as MULTI.
        do_reset();
        chk_all_zero("reset2");
        detect(4'b1010, 4'b0010, c);
        exp_q.push_back('{origin: 2'd1, len: 2'd0, path: 4'b0000, status: 2'(ST_MULTI), cycle: c});
        tok(4'b0110);
        proc_token_vec = '0;
        chk("multi_token_clear", 64'(token_clear), 1);
        tick();
        rif.report_ready = 1'b1;
        tick();
        rif.report_ready = 1'b0;
        chk("multi_halt", 64'(deadlock_halted), 1);

        // No token ever seen: abort after 64 idle trace cycles.
        do_reset();
        detect(4'b0001, 4'b0001, c);
        exp_q.push_back('{origin: 2'd0, len: 2'd0, path: 4'b0000, status: 2'(ST_TIMEOUT), cycle: c});
        for (int i = 0; i < 63; i++) begin
            tick();
            chk("timeout_wait", {62'(token_clear), 2'(dl_detect_in)}, 1);
        end
        tick();
        chk("timeout_token_clear", 64'(token_clear), 1);
        tick();
        rif.report_ready = 1'b1;
        tick();
        rif.report_ready = 1'b0;
        chk("timeout_halt", 64'(deadlock_halted), 1);

        // Path longer than the buffer, then reset while the report waits.
        do_reset();
        detect(4'b0100, 4'b0100, c);
        exp_q.push_back('{origin: 2'd2, len: 2'd2, path: 4'b1100, status: 2'(ST_OVERFLOW), cycle: c});
        tok(4'b0001);
        tok(4'b1000);
        tok(4'b0010);
        proc_token_vec = '0;
        chk("ovf_token_clear", 64'(token_clear), 1);
        tick();
        tick();
        chk("ovf_valid", 64'(rif.report_valid), 1);
        reset = 1'b1;
        tick();
        chk_all_zero("report_reset");
        reset = 1'b0;
        tick();
        chk("post_reset_idle", {60'(origin_vec), 2'(dl_detect_in), 2'(rif.report_valid)}, 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
